// File: rtl/iomem_audio_fifo.sv
// ---------------------------------------------------------------------------
// iomem_audio_fifo
//
// Audio playback buffer on the SoC iomem bus. Firmware pushes stereo
// 16-bit sample pairs, packed as {R[31:16], L[15:0]}, into a FIFO through a
// 16-byte register window. The codec serializer pops one pair per
// sample_req strobe. A level-threshold interrupt lets firmware refill the
// buffer before it runs dry.
//
// Register window (offset = iomem_addr[3:2]):
//   0x0 DATA   W: push wdata                 R: 0
//   0x4 STATUS R: [DEPTH_LOG2:0] level, [16] empty, [17] full, [18] underrun
//              W: wdata[18]=1 clears underrun
//   0x8 CTRL   R/W: [0] enable, [1] irq_en, [15:8] threshold
//              W: wdata[31]=1 (byte 3 strobed) flushes the FIFO, not stored
//   0xC        R: 0, W: ignored
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   iomem_valid       bus request
//   iomem_ready       one-cycle acknowledge
//   iomem_wstrb       byte write strobes, 0 = read
//   iomem_addr        byte address
//   iomem_wdata       write data
//   iomem_rdata       read data, nonzero only while iomem_ready=1
//   sample_req        one-cycle pop strobe from the codec serializer
//   sample_l/sample_r popped left/right sample
//   sample_valid      one-cycle pulse when sample_l/r are updated
//   irq               level interrupt: irq_en && level <= threshold
// ---------------------------------------------------------------------------
module iomem_audio_fifo #(
  parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
  parameter int          DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  input  logic        sample_req,
  output logic [15:0] sample_l,
  output logic [15:0] sample_r,
  output logic        sample_valid,
  output logic        irq
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int LVL_W = DEPTH_LOG2 + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // FIFO storage and bookkeeping
  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [LVL_W-1:0]      level;
  logic                  fifo_empty;
  logic                  fifo_full;

  // Control / status state
  logic       ctrl_enable;
  logic       ctrl_irq_en;
  logic [7:0] ctrl_thresh;
  logic       underrun;

  // Request-stage decode
  logic        sel_p0;
  logic [1:0]  off_p0;
  logic        wr_p0;
  logic        pop_req_p0;
  logic        pop_p0;
  logic        stall_p0;
  logic        ack_p0;
  logic        push_p0;
  logic        ctrl_wr_p0;
  logic        flush_p0;
  logic        clr_und_p0;
  logic        irq_p0;
  logic [31:0] rdata_p0;

  // Address bits below word granularity carry no information here.
  logic unused_addr_lsb;
  assign unused_addr_lsb = &{1'b0, iomem_addr[1:0]};

  // Packs the STATUS read word.
  function automatic logic [31:0] status_word(input logic [LVL_W-1:0] lvl,
                                              input logic             emp,
                                              input logic             ful,
                                              input logic             und);
    logic [31:0] w;
    w                = '0;
    w[DEPTH_LOG2:0]  = lvl;
    w[16]            = emp;
    w[17]            = ful;
    w[18]            = und;
    return w;
  endfunction

  // Packs the CTRL read word; unimplemented bits read as zero.
  function automatic logic [31:0] ctrl_word(input logic       en,
                                            input logic       ien,
                                            input logic [7:0] thr);
    logic [31:0] w;
    w       = '0;
    w[0]    = en;
    w[1]    = ien;
    w[15:8] = thr;
    return w;
  endfunction

  // Zero-extended compare so the threshold works for any DEPTH_LOG2.
  function automatic logic level_at_or_below(input logic [LVL_W-1:0] lvl,
                                             input logic [7:0]       thr);
    return 32'(lvl) <= 32'(thr);
  endfunction

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LVL_FULL);

  // ---- stage p0: bus decode, stall and pop qualification ----
  always_comb begin
    sel_p0     = iomem_valid && (iomem_addr[31:4] == BASE_ADDR[31:4]);
    off_p0     = iomem_addr[3:2];
    wr_p0      = |iomem_wstrb;
    pop_req_p0 = sample_req && ctrl_enable;
    pop_p0     = pop_req_p0 && !fifo_empty;
    // A DATA write into a full FIFO waits for a pop in the same cycle to free
    // a slot; the ack is simply withheld so the CPU keeps the request up.
    stall_p0   = sel_p0 && wr_p0 && (off_p0 == REG_DATA) && fifo_full && !pop_p0;
    // The !iomem_ready term keeps a still-asserted valid from being
    // acknowledged twice while the CPU drops it after the first ack.
    ack_p0     = sel_p0 && !iomem_ready && !stall_p0;
    push_p0    = ack_p0 && wr_p0 && (off_p0 == REG_DATA);
    ctrl_wr_p0 = ack_p0 && wr_p0 && (off_p0 == REG_CTRL);
    flush_p0   = ctrl_wr_p0 && iomem_wstrb[3] && iomem_wdata[31];
    clr_und_p0 = ack_p0 && wr_p0 && (off_p0 == REG_STATUS) && iomem_wdata[18];
    irq_p0     = ctrl_irq_en && level_at_or_below(level, ctrl_thresh);
  end

  always_comb begin
    rdata_p0 = '0;
    if (ack_p0 && !wr_p0) begin
      case (off_p0)
        REG_STATUS: rdata_p0 = status_word(level, fifo_empty, fifo_full, underrun);
        REG_CTRL:   rdata_p0 = ctrl_word(ctrl_enable, ctrl_irq_en, ctrl_thresh);
        default:    rdata_p0 = '0;
      endcase
    end
  end

  // ---- stage p1: committed state and registered outputs ----
  always_ff @(posedge clk) begin
    if (push_p0) begin
      mem[wr_ptr] <= iomem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iomem_ready  <= 1'b0;
      iomem_rdata  <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      ctrl_enable  <= 1'b0;
      ctrl_irq_en  <= 1'b0;
      ctrl_thresh  <= '0;
      underrun     <= 1'b0;
      sample_valid <= 1'b0;
      sample_l     <= '0;
      sample_r     <= '0;
      irq          <= 1'b0;
    end else begin
      iomem_ready <= ack_p0;
      iomem_rdata <= rdata_p0;

      if (flush_p0) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push_p0) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop_p0) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        // Simultaneous push and pop cancel out.
        level <= level + LVL_W'(push_p0) - LVL_W'(pop_p0);
      end

      if (ctrl_wr_p0) begin
        if (iomem_wstrb[0]) begin
          ctrl_enable <= iomem_wdata[0];
          ctrl_irq_en <= iomem_wdata[1];
        end
        if (iomem_wstrb[1]) begin
          ctrl_thresh <= iomem_wdata[15:8];
        end
      end

      // A fresh underrun wins over a clear landing in the same cycle so the
      // event is never lost.
      if (pop_req_p0 && fifo_empty) begin
        underrun <= 1'b1;
      end else if (clr_und_p0) begin
        underrun <= 1'b0;
      end

      sample_valid <= pop_req_p0;
      if (pop_req_p0) begin
        if (pop_p0) begin
          sample_l <= mem[rd_ptr][15:0];
          sample_r <= mem[rd_ptr][31:16];
        end else begin
          sample_l <= '0;
          sample_r <= '0;
        end
      end

      irq <= irq_p0;
    end
  end

endmodule

// File: tb/tb_iomem_audio_fifo.sv
module tb_iomem_audio_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        sample_req;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        sample_valid;
  logic        irq;

  localparam logic [31:0] A_DATA   = 32'h0300_0000;
  localparam logic [31:0] A_STATUS = 32'h0300_0004;
  localparam logic [31:0] A_CTRL   = 32'h0300_0008;

  iomem_audio_fifo #(.BASE_ADDR(32'h0300_0000), .DEPTH_LOG2(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .iomem_valid  (iomem_valid),
    .iomem_ready  (iomem_ready),
    .iomem_wstrb  (iomem_wstrb),
    .iomem_addr   (iomem_addr),
    .iomem_wdata  (iomem_wdata),
    .iomem_rdata  (iomem_rdata),
    .sample_req   (sample_req),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        chk;
    logic [31:0] val;
    string       nm;
  } bus_exp_t;

  bus_exp_t    bus_q[$];
  logic [31:0] samp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic        bus_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT presents a
  // bus ack or a sample pulse.
  bus_exp_t    mon_be;
  logic [31:0] mon_se;
  always @(negedge clk) begin
    if (!reset) begin
      if (iomem_ready) begin
        if (bus_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack: got ack rdata=0x%08h expected no ack at %0t", iomem_rdata, $time);
        end else begin
          mon_be = bus_q.pop_front();
          if (mon_be.chk) chk(mon_be.nm, iomem_rdata, mon_be.val);
        end
      end
      if (sample_valid) begin
        if (samp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_sample: got {r,l}=0x%04h%04h expected no sample at %0t", sample_r, sample_l, $time);
        end else begin
          mon_se = samp_q.pop_front();
          chk("sample_rl", {sample_r, sample_l}, mon_se);
        end
      end
    end
  end

  // Issues one bus access and waits (bounded) for its ack.
  task automatic bus_access(input logic [31:0] addr, input logic [3:0] strb,
                            input logic [31:0] data, input logic do_chk,
                            input logic [31:0] exp, input string nm);
    bus_exp_t e;
    logic     got;
    e.chk = do_chk;
    e.val = exp;
    e.nm  = nm;
    bus_q.push_back(e);
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = strb;
    iomem_wdata = data;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (iomem_ready) got = 1'b1;
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout %s: got no ack expected ack within 40 cycles", nm);
      void'(bus_q.pop_back());
    end
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string nm);
    bus_access(addr, 4'h0, 32'h0, 1'b1, exp, nm);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus_access(addr, 4'hF, data, 1'b0, 32'h0, "write");
  endtask

  task automatic sample_pulse(input logic expect_out, input logic [31:0] exp);
    if (expect_out) samp_q.push_back(exp);
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
  endtask

  function automatic logic [31:0] vec_a(input int i);
    return 32'h1000_2000 + 32'(i) * 32'h0001_0001;
  endfunction

  function automatic logic [31:0] vec_b(input int i);
    return 32'h3000_4000 + 32'(i) * 32'h0010_0003;
  endfunction

  initial begin
    int rc;
    reset       = 1'b1;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    iomem_addr  = 32'h0;
    iomem_wdata = 32'h0;
    sample_req  = 1'b0;
    bus_done    = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_ready", 32'(iomem_ready), 32'd0);
    chk("rst_rdata", iomem_rdata, 32'h0);
    chk("rst_sample_valid", 32'(sample_valid), 32'd0);
    chk("rst_sample", {sample_r, sample_l}, 32'h0);
    chk("rst_irq", 32'(irq), 32'd0);
    reset = 1'b0;
    tick();

    rd(A_STATUS, 32'h0001_0000, "status_after_reset");
    chk("irq_after_reset", 32'(irq), 32'd0);

    // Basic push / pop with threshold interrupt
    wr(A_CTRL, 32'h0000_0103);
    wr(A_DATA, 32'h1111_AAAA);
    wr(A_DATA, 32'h2222_BBBB);
    tick(); tick();
    chk("irq_level2_thr1", 32'(irq), 32'd0);
    rd(A_CTRL, 32'h0000_0103, "ctrl_readback");
    sample_pulse(1'b1, 32'h1111_AAAA);
    tick();
    rd(A_STATUS, 32'h0000_0001, "status_level1");
    tick(); tick();
    chk("irq_level1_thr1", 32'(irq), 32'd1);
    sample_pulse(1'b1, 32'h2222_BBBB);
    tick();

    // Fill to full across the pointer wrap, then stall a 17th write
    for (int i = 0; i < 16; i++) wr(A_DATA, vec_a(i));
    rd(A_STATUS, 32'h0002_0010, "status_full");
    bus_done = 1'b0;
    fork
      begin
        wr(A_DATA, 32'h5A5A_A5A5);
        bus_done = 1'b1;
      end
    join_none
    rc = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (iomem_ready) rc++;
    end
    chk("stall_no_ack", 32'(rc), 32'd0);
    sample_pulse(1'b1, vec_a(0));
    for (int i = 0; i < 20 && !bus_done; i++) tick();
    chk("stall_released", 32'(bus_done), 32'd1);
    rd(A_STATUS, 32'h0002_0010, "status_full_after_swap");
    for (int i = 1; i < 16; i++) sample_pulse(1'b1, vec_a(i));
    sample_pulse(1'b1, 32'h5A5A_A5A5);
    tick();
    rd(A_STATUS, 32'h0001_0000, "status_drained");

    // Underrun and its clear
    sample_pulse(1'b1, 32'h0000_0000);
    tick();
    rd(A_STATUS, 32'h0005_0000, "status_underrun");
    chk("irq_empty_thr1", 32'(irq), 32'd1);
    wr(A_STATUS, 32'h0004_0000);
    rd(A_STATUS, 32'h0001_0000, "status_underrun_cleared");

    // Access outside the window is never acknowledged
    iomem_valid = 1'b1;
    iomem_addr  = 32'h0300_0010;
    iomem_wstrb = 4'h0;
    rc = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (iomem_ready) rc++;
    end
    chk("outside_window_no_ack", 32'(rc), 32'd0);
    iomem_valid = 1'b0;
    tick();

    // Flush through CTRL
    for (int i = 0; i < 5; i++) wr(A_DATA, vec_b(i));
    rd(A_STATUS, 32'h0000_0005, "status_level5");
    wr(A_CTRL, 32'h8000_0001);
    rd(A_STATUS, 32'h0001_0000, "status_flushed");
    rd(A_CTRL, 32'h0000_0001, "ctrl_after_flush");
    chk("irq_disabled", 32'(irq), 32'd0);
    rd(A_DATA, 32'h0000_0000, "data_reads_zero");

    // sample_req ignored while disabled
    wr(A_CTRL, 32'h0000_0000);
    sample_pulse(1'b0, 32'h0);
    tick(); tick();
    rd(A_STATUS, 32'h0001_0000, "status_disabled_no_underrun");

    // Reset during a stalled DATA write
    wr(A_CTRL, 32'h0000_FF03);
    for (int i = 0; i < 16; i++) wr(A_DATA, vec_b(i));
    sample_pulse(1'b1, vec_b(0));
    wr(A_DATA, 32'hCAFE_F00D);
    tick();
    chk("irq_thr255", 32'(irq), 32'd1);
    iomem_valid = 1'b1;
    iomem_addr  = A_DATA;
    iomem_wstrb = 4'hF;
    iomem_wdata = 32'hDEAD_BEEF;
    rc = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (iomem_ready) rc++;
    end
    chk("stall_before_reset", 32'(rc), 32'd0);
    reset = 1'b1;
    tick();
    chk("midrst_ready", 32'(iomem_ready), 32'd0);
    chk("midrst_rdata", iomem_rdata, 32'h0);
    chk("midrst_sample_valid", 32'(sample_valid), 32'd0);
    chk("midrst_sample", {sample_r, sample_l}, 32'h0);
    chk("midrst_irq", 32'(irq), 32'd0);
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    tick();
    reset = 1'b0;
    tick();
    rd(A_STATUS, 32'h0001_0000, "status_after_midrst");
    rd(A_CTRL, 32'h0000_0000, "ctrl_after_midrst");

    repeat (4) tick();
    chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
    chk("sample_queue_drained", 32'(samp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/iomem_audio_fifo.md
Name: iomem_audio_fifo

Overview:
Memory-mapped audio playback buffer on the SoC iomem bus, decoded in the iomem region (mem_addr[31:24] > 0x01). Firmware pushes stereo 16-bit sample pairs into a FIFO. The codec-side serializer pops one pair per sample strobe. A level-threshold interrupt drives one of the SoC external IRQ inputs (irq_5) so firmware can refill before underrun.

Parameters:
BASE_ADDR, 32'h0300_0000, base of 16-byte register window (addr[31:4] match)
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries of 32 bits

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
iomem_valid  in  1  bus request from SoC
iomem_ready  out  1  bus acknowledge, one-cycle pulse
iomem_wstrb  in  4  byte write strobes; 0 = read
iomem_addr  in  32  byte address
iomem_wdata  in  32  write data
iomem_rdata  out  32  read data, valid while iomem_ready=1, else 0
sample_req  in  1  one-cycle pop strobe from codec serializer
sample_l  out  16  left sample
sample_r  out  16  right sample
sample_valid  out  1  one-cycle pulse, sample_l/r updated
irq  out  1  level interrupt (to irq_5)

Behaviour:
- Reset: iomem_ready=0, iomem_rdata=0, sample_l=0, sample_r=0, sample_valid=0, irq=0; FIFO empty, level=0; CTRL=0; underrun=0.
- Select: sel = iomem_valid && iomem_addr[31:4]==BASE_ADDR[31:4]. When sel=0, never assert iomem_ready.
- Registers (offset = addr[3:2]):
  - 0x0 DATA: write of any nonzero wstrb pushes wdata as one entry, {R[31:16], L[15:0]}. Read returns 0.
  - 0x4 STATUS: read returns [DEPTH_LOG2:0]=level, [16]=empty, [17]=full, [18]=underrun. Write with wdata[18]=1 clears underrun; other bits are ignored.
  - 0x8 CTRL: R/W, byte strobes honoured. [0]=enable, [1]=irq_en, [15:8]=threshold. Other bits read 0.
  - 0xC: reads 0; writes ignored; still acked.
- Handshake: iomem_ready <= sel && !iomem_ready && !stall, so the ack comes one cycle after valid at the earliest. Exactly one push or register effect per ack, committed in the ack cycle. rdata is registered alongside ready.
- stall = DATA write while full && !pop_this_cycle. Ack is withheld until space exists; no data is dropped.
- Pop: on sample_req && enable:
  - If not empty: read the head entry, sample_l/r <= entry next cycle, sample_valid=1 for that cycle.
  - If empty: sample_l/r <= 0, sample_valid=1, underrun <= 1.
  - sample_req with enable=0: ignored; outputs hold their values.
- Simultaneous push and pop: both take effect and level is unchanged. When full, a pop in the same cycle lets the pending push commit. When empty, the pop sees empty (underrun) and the push still lands.
- Pointers: DEPTH_LOG2-bit, wrap modulo depth. Level is DEPTH_LOG2+1 bits; full when level == 2**DEPTH_LOG2.
- Clearing enable does not flush the FIFO. A write to CTRL with wdata[31]=1 flushes (level=0, pointers=0); bit 31 itself is not stored.
- irq (registered) = irq_en && level <= threshold. It deasserts the cycle after level exceeds threshold.
- Reset mid-transaction: all state returns to reset values. Any pending ack is dropped and the CPU retries after its own reset.

Test Plan:
- Reset, then read STATUS at 0x0300_0004 -> one ack pulse, rdata=0x0001_0000 (empty, level 0); irq=0.
- Write CTRL=0x0000_0103 (enable, irq_en, threshold=1), push 0x1111_AAAA and 0x2222_BBBB, then pulse sample_req -> next cycle sample_valid=1, sample_l=0xAAAA, sample_r=0x1111. STATUS level=1; irq=1 once level<=1.
- Push 16 entries, issue a 17th DATA write with no sample_req -> iomem_ready stays 0. Pulse sample_req -> 17th write acked that cycle, level stays 16, and output order matches push order across the pointer wrap.
- Enable with FIFO empty, pulse sample_req -> sample_valid=1, sample_l/r=0, STATUS bit18=1. Write STATUS 0x0004_0000 -> bit18 reads 0.
- Access 0x0300_0010 (outside window) -> iomem_ready never asserts within 8 cycles.
- Push 5 entries, write CTRL 0x8000_0001 -> level=0, empty=1, CTRL reads 0x0000_0001. Assert reset during a stalled DATA write -> all outputs at reset values the next cycle.
